// File: rtl/vp_timing_gen_if.sv
// Video stream bundle for vp_timing_gen: run/pattern controls in, de/sync/pixel stream out.
// master is the generator side, slave is the consumer/controller side.
interface vp_timing_gen_if;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [23:0] color_in;
    logic        de_out;
    logic        h_sync_out;
    logic        v_sync_out;
    logic [23:0] pixel_out;
    logic        frame_start;

    modport master (
        input  enable, pattern_sel, color_in,
        output de_out, h_sync_out, v_sync_out, pixel_out, frame_start
    );

    modport slave (
        output enable, pattern_sel, color_in,
        input  de_out, h_sync_out, v_sync_out, pixel_out, frame_start
    );
endinterface

// File: rtl/vp_timing_gen.sv
// Raster timing generator with test-pattern fill. Every output is registered from the
// counter state of the previous cycle, so de, syncs, pixel and frame_start stay aligned.
module vp_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    vp_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // h needs at least 8 bits for the gradient and v at least 4 for the checkerboard.
    localparam int H_W     = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
    localparam int V_W     = ($clog2(V_TOTAL) > 4) ? $clog2(V_TOTAL) : 4;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int B_W     = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;

    localparam logic [H_W-1:0] H_LAST    = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT_END = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_START  = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST    = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT_END = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_START  = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [B_W-1:0] BAR_LAST  = B_W'(BAR_W - 1);
    localparam logic           SYNC_OFF  = ~SYNC_POL;

    logic [H_W-1:0] h_cnt_q, h_cnt_d;
    logic [V_W-1:0] v_cnt_q, v_cnt_d;
    logic [B_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]     bar_idx_q, bar_idx_d;
    logic [1:0]     pat_q, pat_d;
    logic [23:0]    col_q, col_d;
    logic           de_q, de_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic [23:0]    pix_q, pix_d;
    logic           fs_q, fs_d;

    logic           at_origin;
    logic           active;
    logic [1:0]     pat_eff;
    logic [23:0]    col_eff;
    logic [23:0]    pattern_px;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'h00FFFF;
            3'd2:    c = 24'hFFFF00;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'h0000FF;
            3'd6:    c = 24'hFF0000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    always_comb begin
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        active    = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
        // Pixel (0,0) already belongs to the new frame, so bypass the shadow there.
        pat_eff   = at_origin ? vif.pattern_sel : pat_q;
        col_eff   = at_origin ? vif.color_in    : col_q;

        case (pat_eff)
            2'd0:    pattern_px = bar_color(bar_idx_q);
            2'd1:    pattern_px = {3{h_cnt_q[7:0]}};
            2'd2:    pattern_px = (h_cnt_q[3] ^ v_cnt_q[3]) ? 24'h000000 : 24'hFFFFFF;
            default: pattern_px = col_eff;
        endcase

        h_cnt_d   = '0;
        v_cnt_d   = '0;
        bar_cnt_d = '0;
        bar_idx_d = '0;
        pat_d     = pat_q;
        col_d     = col_q;
        de_d      = 1'b0;
        hs_d      = SYNC_OFF;
        vs_d      = SYNC_OFF;
        pix_d     = '0;
        fs_d      = 1'b0;

        if (vif.enable) begin
            de_d  = active;
            hs_d  = (h_cnt_q >= HS_START && h_cnt_q < HS_END) ? SYNC_POL : SYNC_OFF;
            vs_d  = (v_cnt_q >= VS_START && v_cnt_q < VS_END) ? SYNC_POL : SYNC_OFF;
            pix_d = active ? pattern_px : 24'h000000;
            fs_d  = at_origin;
            if (at_origin) begin
                pat_d = vif.pattern_sel;
                col_d = vif.color_in;
            end
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + H_W'(1);
                v_cnt_d = v_cnt_q;
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + B_W'(1);
                    bar_idx_d = bar_idx_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
            col_q     <= '0;
            de_q      <= 1'b0;
            hs_q      <= SYNC_OFF;
            vs_q      <= SYNC_OFF;
            pix_q     <= '0;
            fs_q      <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            col_q     <= col_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            pix_q     <= pix_d;
            fs_q      <= fs_d;
        end
    end

    assign vif.de_out      = de_q;
    assign vif.h_sync_out  = hs_q;
    assign vif.v_sync_out  = vs_q;
    assign vif.pixel_out   = pix_q;
    assign vif.frame_start = fs_q;
endmodule

// File: tb/tb_vp_timing_gen.sv
// Bench for vp_timing_gen on a 24x8 raster: outputs compared every cycle against a
// position-based reference model (position since restart -> h, v -> expected outputs).
module tb_vp_timing_gen;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    vp_timing_gen_if vif ();

    vp_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .vif  (vif)
    );

    always #5 clk = ~clk;

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                              24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

    int          pos = 0;
    logic [1:0]  sh_sel = 2'd0;
    logic [23:0] sh_col = 24'h0;
    logic        e_de, e_hs, e_vs, e_fs;
    logic [23:0] e_px;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h at pos=%0d", tag, obs, exp_v, pos);
        end
    endtask

    task automatic chk_all();
        chk("de", {23'd0, vif.de_out}, {23'd0, e_de});
        chk("hsync", {23'd0, vif.h_sync_out}, {23'd0, e_hs});
        chk("vsync", {23'd0, vif.v_sync_out}, {23'd0, e_vs});
        chk("frame_start", {23'd0, vif.frame_start}, {23'd0, e_fs});
        chk("pixel", vif.pixel_out, e_px);
    endtask

    task automatic set_reset_expect();
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0; e_px = 24'h0;
    endtask

    // Reference: derive line/column from the cycle position and apply the raster rules.
    task automatic model_edge(input logic en, input logic [1:0] sel, input logic [23:0] col);
        int h, v;
        logic [7:0] hb;
        if (!rst_n) begin
            pos = 0; sh_sel = 2'd0; sh_col = 24'h0;
            set_reset_expect();
        end else if (!en) begin
            pos = 0;
            set_reset_expect();
        end else begin
            if (pos % FRAME == 0) begin
                sh_sel = sel; sh_col = col;
            end
            h = pos % HT;
            v = (pos / HT) % VT;
            hb = h[7:0];
            e_de = (h < HA) && (v < VA);
            e_hs = (h >= HA + HFP) && (h < HA + HFP + HS);
            e_vs = (v >= VA + VFP) && (v < VA + VFP + VS);
            e_fs = (h == 0) && (v == 0);
            if (!e_de) e_px = 24'h0;
            else case (sh_sel)
                2'd0: e_px = bars[h / (HA / 8)];
                2'd1: e_px = {hb, hb, hb};
                2'd2: e_px = ((((h >> 3) ^ (v >> 3)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
                default: e_px = sh_col;
            endcase
            pos++;
        end
    endtask

    task automatic step(input logic en, input logic [1:0] sel, input logic [23:0] col);
        vif.enable = en;
        vif.pattern_sel = sel;
        vif.color_in = col;
        @(posedge clk);
        model_edge(en, sel, col);
        #1;
        chk_all();
    endtask

    initial begin
        rst_n = 1'b0;
        vif.enable = 1'b1;
        vif.pattern_sel = 2'd0;
        vif.color_in = 24'h0;

        // Held in reset: outputs must sit at reset values.
        repeat (3) step(1'b1, 2'd0, 24'h0);

        @(negedge clk);
        rst_n = 1'b1;

        // Full bars frame plus the start of the next.
        repeat (FRAME + 5) step(1'b1, 2'd0, 24'h123456);

        // Switch to checkerboard mid-frame: stays bars until the next frame boundary.
        repeat (100) step(1'b1, 2'd2, 24'h0);
        repeat (2 * FRAME) step(1'b1, 2'd2, 24'h0);

        // Random pattern/colour changes every cycle, occasional enable drops.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 59) != 0), 2'($urandom_range(0, 3)), 24'($urandom));
        end

        // Enable drop mid-line, then restart from (0,0).
        repeat (FRAME + 7) step(1'b1, 2'd1, 24'h0);
        repeat (3) step(1'b0, 2'd1, 24'h0);
        repeat (FRAME + 30) step(1'b1, 2'd1, 24'h0);

        // Asynchronous reset mid-frame, checked before the next clock edge.
        repeat (50) step(1'b1, 2'd3, 24'hA5C30F);
        #2;
        rst_n = 1'b0;
        #1;
        pos = 0; sh_sel = 2'd0; sh_col = 24'h0;
        set_reset_expect();
        chk_all();
        repeat (2) step(1'b1, 2'd3, 24'hA5C30F);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME + 10) step(1'b1, 2'd3, 24'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
